branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side dynamic branch predictor. It sits directly upstream of the where-to-go resolution stage and produces that stage's `pc_guessed` input.
- It is trained by that stage's resolved outputs: taken/not-taken, remote target, and prediction success.
- Storage is a direct-mapped branch target buffer (BTB). Each entry holds a tag, a target and a 2-bit saturating counter.
- Lookup is combinational in IF. Training is registered and issued from the resolution stage.

Parameters:
- IDX_BIT, 4, log2 of BTB entry count (16 entries).
- ADDR_BIT, `IM_ADDR_BIT, PC width. Constraint: ADDR_BIT > IDX_BIT + 2.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- if_pc  in  ADDR_BIT  byte PC currently being fetched
- pc_guessed  out  ADDR_BIT  predicted next PC
- pred_taken  out  1  prediction is a BTB redirect
- upd_en  in  1  one resolved control-flow instruction this cycle
- upd_pc  in  ADDR_BIT  PC of the resolved instruction
- upd_taken  in  1  resolution redirected: conditional `branched`, or any jump
- upd_is_jump  in  1  unconditional J26/J32 op
- upd_target  in  ADDR_BIT  resolved `pc_remote`
- upd_succ  in  1  resolution's `pred_succ` (used only with the optional feature)

Behaviour:
- Reset and clocking:
  - Clock is `clk`; reset `rst` is synchronous and active-high.
  - While `rst` is sampled high at a `clk` edge: all valid bits clear, counters become 2'b01, targets and tags are don't-care.
  - Outputs after reset: `pred_taken`=0, `pc_guessed`=`if_pc`+4.
  - `rst` overrides `upd_en` in the same cycle.
- Address split:
  - idx = pc[IDX_BIT+1:2]
  - tag = pc[ADDR_BIT-1:IDX_BIT+2]
  - pc[1:0] is ignored.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - `pred_taken` = hit && (jump[idx] || ctr[idx][1]).
  - `pc_guessed` = `pred_taken` ? target[idx] : `if_pc`+4, truncated to ADDR_BIT (wraps at 2^ADDR_BIT).
- Update (registered; takes effect at the `clk` edge where `upd_en`=1):
  - Entry hit, taken: ctr saturating increment (max 2'b11); target <= `upd_target`; jump <= `upd_is_jump`.
  - Entry hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate (overwrite any previous occupant). valid=1, tag written, target written, ctr=2'b10, jump=`upd_is_jump`.
  - Miss, not taken: no state change.
  - Jump entries: ctr forced to 2'b11 on every update.
- Simultaneous lookup and update to the same index: lookup returns pre-update contents (no bypass). The new contents are visible from the next cycle.
- `upd_en`=0: no state change; all update inputs are don't-care.
- The block has no stall input. IF holds `if_pc` steady during a stall, and the combinational output follows.

Optional Feature:
- Macro: `BP_STATS_EN`.
- When defined:
  - Adds outputs `stat_total` [31:0] and `stat_miss` [31:0].
  - Both reset to 0.
  - `stat_total` increments on each cycle with `upd_en`=1.
  - `stat_miss` increments when `upd_en`=1 and `upd_succ`=0.
  - Both wrap modulo 2^32.
- When undefined: the ports and counters are absent; `upd_succ` is unused.

Decomposition:
- Core.vh additions:
  - `BP_IDX_BIT default.
  - Counter encodings: `BP_CTR_SNT=2'b00, `BP_CTR_WNT=2'b01, `BP_CTR_WT=2'b10, `BP_CTR_ST=2'b11.
  - `BP_CTR_INIT = `BP_CTR_WT.
- Sub-module `sat_ctr2`: combinational next-state for a 2-bit saturating counter (inputs ctr, taken, force_max). One instance is used on the update path.

Test Plan (bench uses ADDR_BIT=12, IDX_BIT=4):
- Reset then lookup `if_pc`=0x040 -> `pred_taken`=0, `pc_guessed`=0x044.
- Update: pc 0x040, taken, target 0x100, branch; next cycle `if_pc`=0x040 -> `pred_taken`=1, `pc_guessed`=0x100.
- Train pc 0x040 with taken, taken, then not-taken ×2 -> counter goes 10→11→11→10→01; prediction stays taken after the first not-taken and becomes `pc_guessed`=0x044 after the second.
- Alias eviction: pc 0x040 taken to 0x100, then pc 0x440 taken to 0x200 (same idx) -> `if_pc`=0x040 now misses (0x044); 0x440 predicts 0x200. Same-cycle lookup of 0x440 during its allocating update returns 0x444.
- Jump at 0x080 to 0x300, then three updates with `upd_taken`=1 -> always predicts 0x300, counter stays at 11. Miss with not-taken at 0x0C0 -> no allocation.
- `BP_STATS_EN`: 5 updates with `upd_succ` pattern 1,0,1,0,0 -> `stat_total`=5, `stat_miss`=3. `rst` asserted together with `upd_en` -> both stats 0, BTB empty.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and defaults for the fetch-side branch predictor.
// Counter encodings are kept in an enum so every file agrees on the meaning
// of each 2-bit state.
package branch_predictor_pkg;

    // Default PC width: a full 32-bit PC unless overridden by parameter
    localparam int BP_ADDR_BIT_DEF = 32;

    // log2 of the BTB entry count
    localparam int BP_IDX_BIT = 4;

    // 2-bit saturating counter states (strongly/weakly not-taken/taken)
    typedef enum logic [1:0] {
        BP_CTR_SNT = 2'b00,
        BP_CTR_WNT = 2'b01,
        BP_CTR_WT  = 2'b10,
        BP_CTR_ST  = 2'b11
    } bp_ctr_e;

    // State given to a freshly allocated conditional-branch entry
    localparam bp_ctr_e BP_CTR_INIT = BP_CTR_WT;

    // State every entry returns to on reset
    localparam bp_ctr_e BP_CTR_RST = BP_CTR_WNT;

    // Counter MSB is the taken/not-taken vote
    function automatic logic bp_ctr_taken(input bp_ctr_e ctr);
        return ctr[1];
    endfunction

endpackage : branch_predictor_pkg

// File: rtl/branch_predictor_sat_ctr2.sv
// Combinational next-state for a 2-bit saturating counter.
// force_max pins the counter at strongly-taken (used for jump entries).
module sat_ctr2
    import branch_predictor_pkg::*;
(
    input  bp_ctr_e ctr,
    input  logic    taken,
    input  logic    force_max,
    output bp_ctr_e ctr_next
);

    // Saturating step up on taken, down on not-taken
    always_comb begin
        ctr_next = ctr;
        if (force_max) begin
            ctr_next = BP_CTR_ST;
        end else if (taken) begin
            case (ctr)
                BP_CTR_SNT: ctr_next = BP_CTR_WNT;
                BP_CTR_WNT: ctr_next = BP_CTR_WT;
                BP_CTR_WT:  ctr_next = BP_CTR_ST;
                default:    ctr_next = BP_CTR_ST;
            endcase
        end else begin
            case (ctr)
                BP_CTR_ST:  ctr_next = BP_CTR_WT;
                BP_CTR_WT:  ctr_next = BP_CTR_WNT;
                BP_CTR_WNT: ctr_next = BP_CTR_SNT;
                default:    ctr_next = BP_CTR_SNT;
            endcase
        end
    end

endmodule : sat_ctr2

// File: rtl/branch_predictor.sv
// Fetch-side dynamic branch predictor built on a direct-mapped BTB.
// Lookup is combinational on if_pc; training arrives from the resolution
// stage and is written at the clock edge with no bypass to the lookup port.
// Optional statistics counters are enabled by defining BP_STATS_EN.
// ADDR_BIT must exceed IDX_BIT + 2 so that the tag field is non-empty.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BIT  = BP_IDX_BIT,
    parameter int ADDR_BIT = BP_ADDR_BIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_BIT-1:0] if_pc,
    output logic [ADDR_BIT-1:0] pc_guessed,
    output logic                pred_taken,
    input  logic                upd_en,
    input  logic [ADDR_BIT-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic                upd_is_jump,
    input  logic [ADDR_BIT-1:0] upd_target,
    input  logic                upd_succ
`ifdef BP_STATS_EN
    ,
    output logic [31:0]         stat_total,
    output logic [31:0]         stat_miss
`endif
);

    localparam int ENTRIES = 1 << IDX_BIT;
    localparam int TAG_BIT = ADDR_BIT - IDX_BIT - 2;

    // BTB storage: valid/counter need a reset, tag/target/jump do not matter
    // until valid is set, but jump is kept with the counter for simplicity.
    logic                valid_reg  [ENTRIES];
    bp_ctr_e             ctr_reg    [ENTRIES];
    logic                jump_reg   [ENTRIES];
    logic [TAG_BIT-1:0]  tag_reg    [ENTRIES];
    logic [ADDR_BIT-1:0] target_reg [ENTRIES];

    // ------------------------------------------------------------------
    // Lookup path
    // ------------------------------------------------------------------
    logic [IDX_BIT-1:0]  if_idx;
    logic [TAG_BIT-1:0]  if_tag;
    logic                if_hit;
    logic [ADDR_BIT-1:0] if_pc_seq;

    assign if_idx    = if_pc[IDX_BIT+1:2];
    assign if_tag    = if_pc[ADDR_BIT-1:IDX_BIT+2];
    assign if_pc_seq = if_pc + ADDR_BIT'(4);

    // Hit needs a valid entry with a matching tag; jumps always redirect
    always_comb begin
        if_hit     = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
        pred_taken = if_hit && (jump_reg[if_idx] || bp_ctr_taken(ctr_reg[if_idx]));
        pc_guessed = pred_taken ? target_reg[if_idx] : if_pc_seq;
    end

    // ------------------------------------------------------------------
    // Update path
    // ------------------------------------------------------------------
    logic [IDX_BIT-1:0]  upd_idx;
    logic [TAG_BIT-1:0]  upd_tag;
    logic                upd_hit;
    logic                upd_force_max;
    bp_ctr_e             upd_ctr_sat;
    bp_ctr_e             upd_ctr_next;
    logic                entry_wr;
    logic                payload_wr;
    logic [ENTRIES-1:0]  entry_sel;

    assign upd_idx = upd_pc[IDX_BIT+1:2];
    assign upd_tag = upd_pc[ADDR_BIT-1:IDX_BIT+2];
    assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);

    // A taken update re-labels the entry with the incoming jump flag; a
    // not-taken update leaves the jump flag alone, so it decides pinning.
    assign upd_force_max = upd_taken ? upd_is_jump : jump_reg[upd_idx];

    sat_ctr2 u_sat_ctr2 (
        .ctr       (ctr_reg[upd_idx]),
        .taken     (upd_taken),
        .force_max (upd_force_max),
        .ctr_next  (upd_ctr_sat)
    );

    // Hits step the counter; allocations start weakly-taken (jumps pinned)
    always_comb begin
        upd_ctr_next = BP_CTR_INIT;
        if (upd_hit) begin
            upd_ctr_next = upd_ctr_sat;
        end else if (upd_is_jump) begin
            upd_ctr_next = BP_CTR_ST;
        end
        // A miss that is not taken never allocates
        entry_wr   = upd_en && (upd_hit || upd_taken);
        // Tag/target/jump/valid are only (re)written on taken updates
        payload_wr = entry_wr && upd_taken;
    end

    // One-hot decode of the entry being trained
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_sel
        assign entry_sel[gi] = (upd_idx == IDX_BIT'(gi));
    end

    // Valid/counter/jump state: reset clears valid and parks counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i] <= 1'b0;
                ctr_reg[i]   <= BP_CTR_RST;
                jump_reg[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (entry_wr && entry_sel[i]) begin
                    ctr_reg[i] <= upd_ctr_next;
                    if (upd_taken) begin
                        valid_reg[i] <= 1'b1;
                        jump_reg[i]  <= upd_is_jump;
                    end
                end
            end
        end
    end

    // Tag/target payload: written on taken updates, reset blocks the write
    always_ff @(posedge clk) begin
        if (!rst && payload_wr) begin
            tag_reg[upd_idx]    <= upd_tag;
            target_reg[upd_idx] <= upd_target;
        end
    end

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef BP_STATS_EN
    logic [31:0] stat_total_reg;
    logic [31:0] stat_miss_reg;

    // Count resolved instructions and mispredictions, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_total_reg <= '0;
            stat_miss_reg  <= '0;
        end else if (upd_en) begin
            stat_total_reg <= stat_total_reg + 32'd1;
            if (!upd_succ) begin
                stat_miss_reg <= stat_miss_reg + 32'd1;
            end
        end
    end

    assign stat_total = stat_total_reg;
    assign stat_miss  = stat_miss_reg;

    // Byte-offset bits of the resolved PC carry no BTB information
    logic unused_upd_bits;
    assign unused_upd_bits = ^upd_pc[1:0];
`else
    // Byte-offset bits and the success flag only matter with statistics
    logic unused_upd_bits;
    assign unused_upd_bits = ^{upd_pc[1:0], upd_succ};
`endif

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (ADDR_BIT=12, IDX_BIT=4).
// Each table row is one clock cycle: lookup outputs are checked before the
// edge that commits that row's update. BP_STATS_EN adds the counter checks.
module tb_branch_predictor;

    localparam int AW = 12;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] if_pc;
    logic [AW-1:0] pc_guessed;
    logic          pred_taken;
    logic          upd_en;
    logic [AW-1:0] upd_pc;
    logic          upd_taken;
    logic          upd_is_jump;
    logic [AW-1:0] upd_target;
    logic          upd_succ;
`ifdef BP_STATS_EN
    logic [31:0]   stat_total;
    logic [31:0]   stat_miss;
`endif

    branch_predictor #(
        .IDX_BIT  (IW),
        .ADDR_BIT (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_pc       (if_pc),
        .pc_guessed  (pc_guessed),
        .pred_taken  (pred_taken),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_is_jump (upd_is_jump),
        .upd_target  (upd_target),
        .upd_succ    (upd_succ)
`ifdef BP_STATS_EN
        ,
        .stat_total  (stat_total),
        .stat_miss   (stat_miss)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          en;
        logic [AW-1:0] upc;
        logic          tk;
        logic          jp;
        logic [AW-1:0] tgt;
        logic [AW-1:0] ipc;
        logic          exp_t;
        logic [AW-1:0] exp_g;
    } vec_t;

    vec_t vq[$];
    int   applied    = 0;
    int   miscompares = 0;

    function automatic vec_t mk(input logic r, input logic e, input logic [AW-1:0] up,
                                input logic t, input logic j, input logic [AW-1:0] tg,
                                input logic [AW-1:0] ip, input logic et,
                                input logic [AW-1:0] eg);
        vec_t v;
        v.rst = r; v.en = e; v.upc = up; v.tk = t; v.jp = j; v.tgt = tg;
        v.ipc = ip; v.exp_t = et; v.exp_g = eg;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; upd_en = v.en; upd_pc = v.upc; upd_taken = v.tk;
        upd_is_jump = v.jp; upd_target = v.tgt; if_pc = v.ipc; upd_succ = 1'b1;
    endtask

    // Drive a row, check the lookup mid-cycle, then let the edge commit it
    task automatic apply(input int n, input vec_t v);
        drive(v);
        @(negedge clk);
        $display("vec %0d: rst=%0b en=%0b upc=%03h tk=%0b jp=%0b tgt=%03h ipc=%03h -> taken=%0b guess=%03h",
                 n, v.rst, v.en, v.upc, v.tk, v.jp, v.tgt, v.ipc, pred_taken, pc_guessed);
        check($sformatf("vec%0d_taken", n), 32'(pred_taken), 32'(v.exp_t));
        check($sformatf("vec%0d_guess", n), 32'(pc_guessed), 32'(v.exp_g));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Two reset edges so the BTB state is defined before any lookup
        drive(mk(1, 0, 0, 0, 0, 0, 12'h040, 0, 0));
        @(posedge clk); @(posedge clk); #1;

        //            rst en upc     tk jp tgt     ipc     et eg
        vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h040, 0, 12'h044)); // reset state
        vq.push_back(mk(0, 1, 12'h040, 1, 0, 12'h100, 12'h040, 0, 12'h044)); // alloc, no bypass
        vq.push_back(mk(0, 1, 12'h040, 1, 0, 12'h100, 12'h040, 1, 12'h100)); // 10 -> 11
        vq.push_back(mk(0, 1, 12'h040, 1, 0, 12'h100, 12'h040, 1, 12'h100)); // 11 -> 11
        vq.push_back(mk(0, 1, 12'h040, 0, 0, 12'h000, 12'h040, 1, 12'h100)); // 11 -> 10
        vq.push_back(mk(0, 1, 12'h040, 0, 0, 12'h000, 12'h040, 1, 12'h100)); // 10 -> 01
        vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h040, 0, 12'h044)); // now not-taken
        vq.push_back(mk(0, 1, 12'h040, 1, 0, 12'h100, 12'h040, 0, 12'h044)); // 01 -> 10
        vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h040, 1, 12'h100));
        vq.push_back(mk(0, 1, 12'h440, 1, 0, 12'h200, 12'h440, 0, 12'h444)); // alias alloc, same-cycle
        vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h040, 0, 12'h044)); // evicted
        vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h440, 1, 12'h200));
        vq.push_back(mk(0, 1, 12'h440, 0, 0, 12'h000, 12'h440, 1, 12'h200)); // 10 -> 01
        vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h440, 0, 12'h444));
        vq.push_back(mk(0, 1, 12'h080, 1, 1, 12'h300, 12'h080, 0, 12'h084)); // jump alloc
        vq.push_back(mk(0, 1, 12'h080, 1, 1, 12'h300, 12'h080, 1, 12'h300));
        vq.push_back(mk(0, 1, 12'h080, 1, 1, 12'h300, 12'h080, 1, 12'h300));
        vq.push_back(mk(0, 1, 12'h080, 1, 1, 12'h300, 12'h080, 1, 12'h300));
        vq.push_back(mk(0, 1, 12'h0C0, 0, 0, 12'h000, 12'h0C0, 0, 12'h0C4)); // miss not-taken
        vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h0C0, 0, 12'h0C4)); // no allocation
        vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h080, 1, 12'h300)); // jump survives
        vq.push_back(mk(0, 0, 12'h0C0, 1, 0, 12'h7FC, 12'h0C0, 0, 12'h0C4)); // upd_en=0 ignored
        vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h0C0, 0, 12'h0C4));
        vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'hFFC, 0, 12'h000)); // +4 wraps
        vq.push_back(mk(0, 1, 12'hFFC, 1, 0, 12'h010, 12'hFFC, 0, 12'h000));
        vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'hFFC, 1, 12'h010));
        vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'hFFE, 1, 12'h010)); // pc[1:0] ignored
        vq.push_back(mk(0, 1, 12'h104, 1, 0, 12'h020, 12'h104, 0, 12'h108)); // alloc 10
        vq.push_back(mk(0, 1, 12'h104, 0, 0, 12'h000, 12'h104, 1, 12'h020)); // 10 -> 01
        vq.push_back(mk(0, 1, 12'h104, 0, 0, 12'h000, 12'h104, 0, 12'h108)); // 01 -> 00
        vq.push_back(mk(0, 1, 12'h104, 0, 0, 12'h000, 12'h104, 0, 12'h108)); // 00 -> 00
        vq.push_back(mk(0, 1, 12'h104, 1, 0, 12'h020, 12'h104, 0, 12'h108)); // 00 -> 01
        vq.push_back(mk(0, 1, 12'h104, 1, 0, 12'h020, 12'h104, 0, 12'h108)); // 01 -> 10
        vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h104, 1, 12'h020));
        vq.push_back(mk(1, 1, 12'h104, 1, 0, 12'h020, 12'h104, 1, 12'h020)); // rst beats upd_en
        vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h104, 0, 12'h108));
        vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h080, 0, 12'h084));

        for (int i = 0; i < vq.size(); i++) begin
            apply(i, vq[i]);
        end

        // Stall: if_pc held for several cycles, output follows steadily
        apply(100, mk(0, 1, 12'h080, 1, 1, 12'h300, 12'h080, 0, 12'h084));
        for (int k = 0; k < 3; k++) begin
            apply(101 + k, mk(0, 0, 12'h000, 0, 0, 12'h000, 12'h080, 1, 12'h300));
        end

        // Statistics: reset, five updates with success 1,0,1,0,0
        drive(mk(1, 0, 0, 0, 0, 0, 12'h200, 0, 0));
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef BP_STATS_EN
        @(negedge clk);
        check("stat_total_reset", stat_total, 32'd0);
        check("stat_miss_reset", stat_miss, 32'd0);
        @(posedge clk); #1;
`endif
        begin
            logic [4:0] succ_pat;
            succ_pat = 5'b00101; // bit k is the success flag of update k
            for (int k = 0; k < 5; k++) begin
                upd_en = 1'b1; upd_pc = 12'h200; upd_taken = 1'b1; upd_is_jump = 1'b0;
                upd_target = 12'h400; upd_succ = succ_pat[k]; if_pc = 12'h200;
                @(posedge clk); #1;
                $display("stats update %0d: succ=%0b", k, succ_pat[k]);
            end
        end
        upd_en = 1'b0;
        @(negedge clk);
`ifdef BP_STATS_EN
        $display("stats: total=%0d miss=%0d", stat_total, stat_miss);
        check("stat_total_5", stat_total, 32'd5);
        check("stat_miss_3", stat_miss, 32'd3);
`endif
        check("trained_0x200_taken", 32'(pred_taken), 32'd1);
        check("trained_0x200_guess", 32'(pc_guessed), 32'h400);

        // Reset together with an update: counters and BTB both cleared
        @(posedge clk); #1;
        rst = 1'b1; upd_en = 1'b1; upd_pc = 12'h300; upd_taken = 1'b1;
        upd_is_jump = 1'b1; upd_target = 12'h500; upd_succ = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; upd_en = 1'b0; if_pc = 12'h200;
        @(negedge clk);
`ifdef BP_STATS_EN
        check("stat_total_rst", stat_total, 32'd0);
        check("stat_miss_rst", stat_miss, 32'd0);
`endif
        $display("after rst+upd: if_pc=200 taken=%0b guess=%03h", pred_taken, pc_guessed);
        check("rst_empty_0x200_taken", 32'(pred_taken), 32'd0);
        check("rst_empty_0x200_guess", 32'(pc_guessed), 32'h204);
        if_pc = 12'h300;
        #1;
        $display("after rst+upd: if_pc=300 taken=%0b guess=%03h", pred_taken, pc_guessed);
        check("rst_empty_0x300_taken", 32'(pred_taken), 32'd0);
        check("rst_empty_0x300_guess", 32'(pc_guessed), 32'h304);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule : tb_branch_predictor
